// File: rtl/quadrilatero_deskew_ctrl_if.sv
// Handshake bundle between the deskew controller and its neighbours: drain
// control, mesh result edge and register-file writeback port.
interface quadrilatero_deskew_ctrl_if #(
  parameter int ROW_W = 3
);
  logic             start_i;
  logic [ROW_W-1:0] rows_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             mesh_valid_i;
  logic             mesh_ready_o;
  logic             pump_o;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [ROW_W-1:0] wb_row_o;
  logic             wb_last_o;

  // Both ports are valid/ready: a beat or row moves only on a cycle where
  // valid and ready are both high; valid never waits on ready, and a
  // presented row stays stable until it is taken.
  modport master (
    input  start_i, rows_i, abort_i, mesh_valid_i, wb_ready_i,
    output busy_o, done_o, mesh_ready_o, pump_o, wb_valid_o, wb_row_o, wb_last_o
  );

  modport slave (
    output start_i, rows_i, abort_i, mesh_valid_i, wb_ready_i,
    input  busy_o, done_o, mesh_ready_o, pump_o, wb_valid_o, wb_row_o, wb_last_o
  );
endinterface

// File: rtl/quadrilatero_deskew_ctrl.sv
// Drain sequencer for the systolic mesh output deskewer: counts skewed beats,
// pumps the deskewer and hands realigned rows to writeback.
module quadrilatero_deskew_ctrl #(
   parameter int MESH_WIDTH = 4,
   parameter int MAX_ROWS   = 4,
   parameter int ROW_W      = $clog2(MAX_ROWS + 1),
   parameter int CNT_W      = $clog2(MAX_ROWS + MESH_WIDTH)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   quadrilatero_deskew_ctrl_if.master        bus,
   output logic [1:0]                        state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  beat_cnt_q;
   logic [ROW_W-1:0]  rows_q;
   logic [ROW_W-1:0]  rows_clamped;
   logic [ROW_W-1:0]  wb_row;
   logic              done_q;
   logic              accept;
   logic              fill_last;
   logic              stream_last;

   assign rows_clamped = (bus.rows_i > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : bus.rows_i;
   assign fill_last    = (beat_cnt_q == CNT_W'(MESH_WIDTH - 2));
   assign stream_last  = (beat_cnt_q == (CNT_W'(rows_q) + CNT_W'(MESH_WIDTH - 2)));
   // Row r is complete while beat r+MESH_WIDTH-1 sits on the deskewer input.
   assign wb_row       = ROW_W'(beat_cnt_q - CNT_W'(MESH_WIDTH - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = (rows_clamped == '0) ? DONE : FILL;
            end
         end
         FILL: begin
            if (bus.abort_i) begin
               state_d = IDLE;
            end else if (accept && fill_last) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (bus.abort_i) begin
               state_d = IDLE;
            end else if (accept && stream_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Abort masks every handshake in its cycle so neither side sees a transfer.
   always_comb begin
      accept           = 1'b0;
      bus.mesh_ready_o = 1'b0;
      bus.wb_valid_o   = 1'b0;
      bus.wb_row_o     = '0;
      bus.wb_last_o    = 1'b0;
      unique case (state_q)
         FILL: begin
            bus.mesh_ready_o = !bus.abort_i;
            accept           = bus.mesh_valid_i && !bus.abort_i;
         end
         STREAM: begin
            bus.wb_valid_o   = bus.mesh_valid_i && !bus.abort_i;
            bus.mesh_ready_o = bus.wb_ready_i && !bus.abort_i;
            accept           = bus.mesh_valid_i && bus.wb_ready_i && !bus.abort_i;
            bus.wb_row_o     = wb_row;
            bus.wb_last_o    = (wb_row == (rows_q - ROW_W'(1)));
         end
         default: begin
         end
      endcase
   end

   assign bus.pump_o = accept;
   assign bus.busy_o = (state_q != IDLE);
   assign bus.done_o = done_q;
   assign state_o    = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt_q <= '0;
         rows_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= (state_d == DONE);
         if (state_q == IDLE) begin
            beat_cnt_q <= '0;
            if (bus.start_i) begin
               rows_q <= rows_clamped;
            end
         end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule
